cmd_mem_bridge: RTL and testbench

CMD_MEM_BRIDGE -- requirements
Module: cmd_mem_bridge

---
 rtl/cmd_mem_bridge.sv | 180 ++++++++++++++++++
 tb/tb_cmd_mem_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_mem_bridge.sv
// Byte-command bridge from a UART register interface to a simple memory port.
// Opcodes load the address/counter registers and run write or read bursts.
module cmd_mem_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              uart_interrupt,
  output logic [3:0]        uart_rcen,
  input  logic              uart_rack,
  input  logic [7:0]        uart_rdata,
  output logic [3:0]        uart_wcen,
  input  logic              uart_wack,
  output logic [7:0]        uart_wdata,
  output logic              mem_cen,
  output logic              mem_wen,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [7:0] ADDR_LAST = 8'(ADDR_W / 8 - 1);
  localparam logic [7:0] CNT_LAST  = 8'(CNT_W / 8 - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_W / 8 - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, LOAD_ADDR, LOAD_CNT, WR_COLLECT, WR_MEM, RD_MEM, RD_TX
  } state_t;

  state_t            state;
  logic              pending;
  logic [7:0]        opcode;
  logic [7:0]        byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] rbuf;
  logic              rx_take;
  logic              consuming;

  assign rx_take   = uart_rcen[0] & uart_rack;
  assign consuming = state inside {FETCH, LOAD_ADDR, LOAD_CNT, WR_COLLECT};
  assign mem_addr  = addr;
  assign mem_wdata = wbuf;

  // Read bursts hold a pending RX byte because RD_MEM/RD_TX never fetch.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      opcode     <= 8'h00;
      byte_idx   <= 8'h00;
      addr       <= '0;
      cnt        <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      uart_rcen  <= 4'b0000;
      uart_wcen  <= 4'b0000;
      uart_wdata <= 8'h00;
      mem_cen    <= 1'b0;
      mem_wen    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (uart_interrupt) begin
        if (pending && !rx_take) err <= 1'b1;
        else                     pending <= 1'b1;
      end else if (rx_take) begin
        pending <= 1'b0;
      end

      if (consuming) begin
        if (rx_take)                       uart_rcen <= 4'b0000;
        else if (!uart_rcen[0] && pending) uart_rcen <= 4'b0001;
      end

      case (state)
        IDLE: if (pending) state <= FETCH;

        FETCH: if (rx_take) begin
          opcode <= uart_rdata;
          state  <= DECODE;
        end

        DECODE: begin
          byte_idx <= 8'h00;
          case (opcode)
            8'h00: state <= IDLE;
            8'h01: state <= LOAD_ADDR;
            8'h02: state <= LOAD_CNT;
            8'h04: state <= (cnt == '0) ? IDLE : WR_COLLECT;
            8'h08: begin
              if (cnt == '0) state <= IDLE;
              else begin
                state   <= RD_MEM;
                mem_cen <= 1'b1;
                mem_wen <= 1'b0;
              end
            end
            default: begin
              err   <= 1'b1;
              state <= IDLE;
            end
          endcase
        end

        LOAD_ADDR: if (rx_take) begin
          addr <= (addr << 8) | ADDR_W'(uart_rdata);
          if (byte_idx == ADDR_LAST) state <= IDLE;
          else byte_idx <= byte_idx + 8'd1;
        end

        LOAD_CNT: if (rx_take) begin
          cnt <= (cnt << 8) | CNT_W'(uart_rdata);
          if (byte_idx == CNT_LAST) state <= IDLE;
          else byte_idx <= byte_idx + 8'd1;
        end

        WR_COLLECT: if (rx_take) begin
          wbuf <= (wbuf << 8) | DATA_W'(uart_rdata);
          if (byte_idx == DATA_LAST) begin
            byte_idx <= 8'h00;
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            state    <= WR_MEM;
          end else begin
            byte_idx <= byte_idx + 8'd1;
          end
        end

        WR_MEM: if (mem_ack) begin
          mem_cen <= 1'b0;
          mem_wen <= 1'b0;
          addr    <= addr + ADDR_W'(ADDR_STEP);
          cnt     <= cnt - CNT_W'(1);
          state   <= (cnt == CNT_W'(1)) ? IDLE : WR_COLLECT;
        end

        RD_MEM: if (mem_ack) begin
          mem_cen  <= 1'b0;
          rbuf     <= mem_rdata;
          byte_idx <= 8'h00;
          state    <= RD_TX;
        end

        // Each TX byte gets its own strobe pulse with a low cycle in between.
        RD_TX: begin
          if (uart_wcen[1]) begin
            if (uart_wack) begin
              uart_wcen <= 4'b0000;
              if (byte_idx == DATA_LAST) begin
                addr <= addr + ADDR_W'(ADDR_STEP);
                cnt  <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= IDLE;
                else begin
                  state   <= RD_MEM;
                  mem_cen <= 1'b1;
                  mem_wen <= 1'b0;
                end
              end else begin
                byte_idx <= byte_idx + 8'd1;
              end
            end
          end else begin
            uart_wcen  <= 4'b0010;
            uart_wdata <= rbuf[DATA_W-1 -: 8];
            rbuf       <= rbuf << 8;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_mem_bridge.sv
// Scoreboard bench for cmd_mem_bridge: an 8-bit instance for the main flows
// and a 16-bit / step-2 instance for wide-word write bursts.
module tb_cmd_mem_bridge;

  logic clk = 1'b0;
  logic areset;

  logic        irq_a, rack_a = 1'b0, wack_a = 1'b0, mem_ack_a = 1'b0;
  logic [7:0]  rdata_a = 8'h00, wdata_a, mem_wdata_a, mem_rdata_a = 8'h00;
  logic [3:0]  rcen_a, wcen_a;
  logic        mem_cen_a, mem_wen_a, err_a;
  logic [31:0] mem_addr_a;

  logic        irq_b, rack_b = 1'b0, wack_b, mem_ack_b = 1'b0;
  logic [7:0]  rdata_b = 8'h00, wdata_b;
  logic [3:0]  rcen_b, wcen_b;
  logic        mem_cen_b, mem_wen_b, err_b;
  logic [31:0] mem_addr_b;
  logic [15:0] mem_wdata_b, mem_rdata_b;

  logic [7:0]  rx_a_q[$], rx_b_q[$];
  logic [63:0] exp_w_q[$], obs_w_q[$];
  logic [31:0] exp_r_q[$], obs_r_q[$];
  logic [7:0]  exp_tx_q[$], obs_tx_q[$];
  logic [7:0]  mem_model[logic [31:0]];

  logic rx_hold, mem_hold, use_b;
  int   mem_dly = 0, mem_wait = 1, excl_viol = 0, rx_extra = 0;
  int   n_checks = 0, n_errors = 0;

  cmd_mem_bridge u_dut_a (
    .clk(clk), .areset(areset), .uart_interrupt(irq_a),
    .uart_rcen(rcen_a), .uart_rack(rack_a), .uart_rdata(rdata_a),
    .uart_wcen(wcen_a), .uart_wack(wack_a), .uart_wdata(wdata_a),
    .mem_cen(mem_cen_a), .mem_wen(mem_wen_a), .mem_ack(mem_ack_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .err(err_a)
  );

  cmd_mem_bridge #(.DATA_W(16), .ADDR_STEP(2)) u_dut_b (
    .clk(clk), .areset(areset), .uart_interrupt(irq_b),
    .uart_rcen(rcen_b), .uart_rack(rack_b), .uart_rdata(rdata_b),
    .uart_wcen(wcen_b), .uart_wack(wack_b), .uart_wdata(wdata_b),
    .mem_cen(mem_cen_b), .mem_wen(mem_wen_b), .mem_ack(mem_ack_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .err(err_b)
  );

  always #5 clk = ~clk;

  // UART and memory responders; they only record what the DUTs do.
  always @(negedge clk) begin
    if ((int'(|rcen_a) + int'(|wcen_a) + int'(mem_cen_a)) > 1 || rcen_a[3:1] != 3'b000 ||
        wcen_a[3:2] != 2'b00 || wcen_a[0] || (int'(|rcen_b) + int'(mem_cen_b)) > 1 ||
        rcen_b[3:1] != 3'b000 || wcen_b != 4'b0000)
      excl_viol++;
    if (areset) begin
      rack_a = 1'b0; wack_a = 1'b0; mem_ack_a = 1'b0; mem_dly = 0;
      rack_b = 1'b0; mem_ack_b = 1'b0;
    end else begin
      if (rack_a) rack_a = 1'b0;
      else if (rcen_a[0] && !rx_hold) begin
        rack_a = 1'b1;
        if (rx_a_q.size() > 0) rdata_a = rx_a_q.pop_front();
        else begin rx_extra++; rdata_a = 8'h00; end
      end
      if (wack_a) wack_a = 1'b0;
      else if (wcen_a[1]) begin
        wack_a = 1'b1;
        obs_tx_q.push_back(wdata_a);
      end
      if (mem_ack_a) mem_ack_a = 1'b0;
      else if (mem_cen_a && !mem_hold) begin
        if (mem_dly < mem_wait) mem_dly++;
        else begin
          mem_ack_a = 1'b1;
          mem_dly   = 0;
          mem_wait  = $urandom_range(0, 2);
          if (mem_wen_a) begin
            mem_model[mem_addr_a] = mem_wdata_a;
            obs_w_q.push_back({mem_addr_a, 24'h0, mem_wdata_a});
          end else begin
            obs_r_q.push_back(mem_addr_a);
            mem_rdata_a = mem_model.exists(mem_addr_a) ? mem_model[mem_addr_a] : 8'h00;
          end
        end
      end
      if (rack_b) rack_b = 1'b0;
      else if (rcen_b[0]) begin
        rack_b = 1'b1;
        if (rx_b_q.size() > 0) rdata_b = rx_b_q.pop_front();
        else begin rx_extra++; rdata_b = 8'h00; end
      end
      if (mem_ack_b) mem_ack_b = 1'b0;
      else if (mem_cen_b) begin
        mem_ack_b = 1'b1;
        if (mem_wen_b) obs_w_q.push_back({mem_addr_b, 16'h0, mem_wdata_b});
        else obs_r_q.push_back(mem_addr_b);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (use_b) begin rx_b_q.push_back(b); irq_b = 1'b1; end
    else begin rx_a_q.push_back(b); irq_a = 1'b1; end
    @(negedge clk);
    irq_a = 1'b0;
    irq_b = 1'b0;
    while ((rx_a_q.size() + rx_b_q.size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_consumed", 64'(rx_a_q.size() + rx_b_q.size()), 0);
  endtask

  task automatic checkScoreboard();
    checkOutput("wr_count", 64'(obs_w_q.size()), 64'(exp_w_q.size()));
    while (obs_w_q.size() > 0 && exp_w_q.size() > 0)
      checkOutput("wr_addr_data", obs_w_q.pop_front(), exp_w_q.pop_front());
    checkOutput("rd_count", 64'(obs_r_q.size()), 64'(exp_r_q.size()));
    while (obs_r_q.size() > 0 && exp_r_q.size() > 0)
      checkOutput("rd_addr", 64'(obs_r_q.pop_front()), 64'(exp_r_q.pop_front()));
    checkOutput("tx_count", 64'(obs_tx_q.size()), 64'(exp_tx_q.size()));
    while (obs_tx_q.size() > 0 && exp_tx_q.size() > 0)
      checkOutput("tx_byte", 64'(obs_tx_q.pop_front()), 64'(exp_tx_q.pop_front()));
    obs_w_q.delete(); exp_w_q.delete(); obs_r_q.delete();
    exp_r_q.delete(); obs_tx_q.delete(); exp_tx_q.delete();
  endtask

  task automatic waitDone();
    int n = 0;
    while ((obs_w_q.size() < exp_w_q.size() || obs_r_q.size() < exp_r_q.size() ||
            obs_tx_q.size() < exp_tx_q.size()) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    checkScoreboard();
  endtask

  task automatic setAddr(input logic [31:0] a);
    applyStimulus(8'h01);
    applyStimulus(a[31:24]); applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);  applyStimulus(a[7:0]);
  endtask

  task automatic setCnt(input logic [7:0] c);
    applyStimulus(8'h02);
    applyStimulus(c);
  endtask

  initial begin
    int n;
    areset = 1'b1; irq_a = 1'b0; irq_b = 1'b0; wack_b = 1'b0; mem_rdata_b = 16'h0;
    rx_hold = 1'b0; mem_hold = 1'b0; use_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_cen", mem_cen_a, 0);
    checkOutput("rst_rcen", rcen_a, 0);
    checkOutput("rst_wcen", wcen_a, 0);
    checkOutput("rst_err", err_a, 0);
    checkOutput("rst_addr", mem_addr_a, 0);
    areset = 1'b0;

    // Three-word write burst, then a one-word burst from the persisted address.
    exp_w_q.push_back({32'hA0B0C0D0, 32'h11});
    exp_w_q.push_back({32'hA0B0C0D1, 32'h22});
    exp_w_q.push_back({32'hA0B0C0D2, 32'h33});
    setAddr(32'hA0B0C0D0); setCnt(8'h03);
    applyStimulus(8'h04); applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    waitDone();
    exp_w_q.push_back({32'hA0B0C0D3, 32'h44});
    setCnt(8'h01); applyStimulus(8'h04); applyStimulus(8'h44);
    waitDone();

    // Counter left at zero: a write burst does nothing.
    applyStimulus(8'h04);
    waitDone();
    checkOutput("err_after_zero_burst", err_a, 0);

    // Read the first three words back over TX.
    exp_r_q.push_back(32'hA0B0C0D0); exp_r_q.push_back(32'hA0B0C0D1); exp_r_q.push_back(32'hA0B0C0D2);
    exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22); exp_tx_q.push_back(8'h33);
    setAddr(32'hA0B0C0D0); setCnt(8'h03); applyStimulus(8'h08);
    waitDone();

    applyStimulus(8'h00);
    waitDone();
    checkOutput("err_after_nop", err_a, 0);

    // Address wrap at the top of the space.
    exp_w_q.push_back({32'hFFFFFFFF, 32'h5A});
    exp_w_q.push_back({32'h00000000, 32'hA5});
    setAddr(32'hFFFFFFFF); setCnt(8'h02);
    applyStimulus(8'h04); applyStimulus(8'h5A); applyStimulus(8'hA5);
    waitDone();

    applyStimulus(8'h55);
    waitDone();
    checkOutput("err_bad_opcode", err_a, 1);
    @(negedge clk); areset = 1'b1;
    @(negedge clk); areset = 1'b0;
    checkOutput("err_cleared", err_a, 0);

    // Overrun: second interrupt while the first byte is still unread.
    rx_hold = 1'b1;
    rx_a_q.push_back(8'h00);
    @(negedge clk); irq_a = 1'b1; @(negedge clk); irq_a = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rcen_waiting", rcen_a, 4'b0001);
    irq_a = 1'b1; @(negedge clk); irq_a = 1'b0;
    @(negedge clk);
    checkOutput("err_overrun", err_a, 1);
    rx_hold = 1'b0;
    n = 0;
    while (rx_a_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    checkOutput("held_byte_read", 64'(rx_a_q.size()), 0);
    checkOutput("err_sticky", err_a, 1);

    // Reset while a memory write waits for its acknowledge.
    setAddr(32'h00000040); setCnt(8'h01);
    mem_hold = 1'b1;
    applyStimulus(8'h04); applyStimulus(8'h77);
    n = 0;
    while (!mem_cen_a && n < 50) begin @(negedge clk); n++; end
    checkOutput("mem_req_pending", mem_cen_a, 1);
    checkOutput("mem_req_addr", mem_addr_a, 32'h40);
    checkOutput("mem_req_data", mem_wdata_a, 8'h77);
    #2 areset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_cen", mem_cen_a, 0);
    checkOutput("rst_mid_mem_wen", mem_wen_a, 0);
    checkOutput("rst_mid_addr", mem_addr_a, 0);
    checkOutput("rst_mid_err", err_a, 0);
    @(negedge clk); areset = 1'b0; mem_hold = 1'b0;
    waitDone();
    applyStimulus(8'h00);
    waitDone();
    checkOutput("err_after_reset_nop", err_a, 0);
    exp_w_q.push_back({32'h00000000, 32'h66});
    setCnt(8'h01); applyStimulus(8'h04); applyStimulus(8'h66);
    waitDone();

    // 16-bit words with an address step of two.
    use_b = 1'b1;
    exp_w_q.push_back({32'h00001000, 32'hABCD});
    exp_w_q.push_back({32'h00001002, 32'h1234});
    setAddr(32'h00001000); setCnt(8'h02);
    applyStimulus(8'h04); applyStimulus(8'hAB); applyStimulus(8'hCD);
    applyStimulus(8'h12); applyStimulus(8'h34);
    waitDone();
    checkOutput("err_b", err_b, 0);

    checkOutput("strobe_exclusion", 64'(excl_viol), 0);
    checkOutput("rx_without_pending", 64'(rx_extra), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
